// File: rtl/l15_req_arbiter.sv
// Shares the L1.5 transducer request port among NUM_REQ requesters, each with a one-entry holding buffer.
// Optional macro L15_REQ_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module l15_req_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_val,
    input  logic [5*NUM_REQ-1:0]    req_rqtype,
    input  logic [3*NUM_REQ-1:0]    req_size,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [64*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_busy,
    output logic [NUM_REQ-1:0]      req_overflow,
    input  logic                    l15_header_ack,
    input  logic                    l15_ack,
    output logic                    out_val,
    output logic [4:0]              out_rqtype,
    output logic [2:0]              out_size,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [63:0]             out_data,
    output logic                    out_nc,
    output logic [2:0]              out_grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  busy;
    logic [NUM_REQ-1:0]  ovf;
    logic [NUM_REQ-1:0]  release_vec;
    logic [4:0]          buf_rqtype [NUM_REQ];
    logic [2:0]          buf_size   [NUM_REQ];
    logic [ADDR_W-1:0]   buf_addr   [NUM_REQ];
    logic [63:0]         buf_data   [NUM_REQ];

    logic                pick_val;
    logic [2:0]          pick_id;
    logic [4:0]          sel_rqtype;
    logic [2:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic [63:0]         sel_data;

    assign req_busy     = busy;
    assign req_overflow = ovf;
    assign out_nc       = out_addr[ADDR_W-1];

    // Only an ack while a grant is outstanding frees its buffer.
    always_comb begin
        release_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            release_vec[i] = (state != IDLE) && l15_ack && (out_grant_id == 3'(i));
        end
    end

`ifdef L15_REQ_ARB_ROUND_ROBIN_EN
    logic [2:0]           rr_ptr;
    logic [2*NUM_REQ-1:0] rot;

    // Rotate so bit 0 is the index just after the pointer; the lowest set bit wins.
    always_comb begin
        pick_val = |busy;
        pick_id  = '0;
        rot      = {busy, busy} >> ({1'b0, rr_ptr} + 4'd1);
        for (int unsigned j = NUM_REQ; j > 0; j--) begin
            if (rot[j-1]) pick_id = 3'((32'(rr_ptr) + j) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= 3'(NUM_REQ - 1);
        else if (state == IDLE && pick_val)
            rr_ptr <= pick_id;
    end
`else
    always_comb begin
        pick_val = |busy;
        pick_id  = '0;
        for (int unsigned j = NUM_REQ; j > 0; j--) begin
            if (busy[j-1]) pick_id = 3'(j - 1);
        end
    end
`endif

    always_comb begin
        sel_rqtype = '0;
        sel_size   = '0;
        sel_addr   = '0;
        sel_data   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_id == 3'(i)) begin
                sel_rqtype = buf_rqtype[i];
                sel_size   = buf_size[i];
                sel_addr   = buf_addr[i];
                sel_data   = buf_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
            ovf  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_val[i] && (!busy[i] || release_vec[i])) begin
                    busy[i] <= 1'b1;
                end else begin
                    if (release_vec[i]) busy[i] <= 1'b0;
                    if (req_val[i])     ovf[i]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_val[i] && (!busy[i] || release_vec[i])) begin
                buf_rqtype[i] <= req_rqtype[5*i +: 5];
                buf_size[i]   <= req_size[3*i +: 3];
                buf_addr[i]   <= req_addr[ADDR_W*i +: ADDR_W];
                buf_data[i]   <= req_data[64*i +: 64];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_val      <= 1'b0;
            out_rqtype   <= '0;
            out_size     <= '0;
            out_addr     <= '0;
            out_data     <= '0;
            out_grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_val <= 1'b0;
                    if (pick_val) begin
                        out_rqtype   <= sel_rqtype;
                        out_size     <= sel_size;
                        out_addr     <= sel_addr;
                        out_data     <= sel_data;
                        out_grant_id <= pick_id;
                        out_val      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (l15_ack) begin
                        out_val <= 1'b0;
                        state   <= IDLE;
                    end else if (l15_header_ack) begin
                        out_val <= 1'b0;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    out_val <= 1'b0;
                    if (l15_ack) state <= IDLE;
                end
                default: begin
                    out_val <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Shares the single L1.5 transducer request port among NUM_REQ core-side requesters (default 3: 0 = imiss, 1 = load, 2 = store).
- Each requester gets a one-entry holding buffer. An arbiter picks one pending buffer, presents it to L1.5, and holds it until the ack/header_ack handshake completes.
- Sits between core-side miss/store logic and the L1.5 transducer inputs. Replaces ad-hoc per-source state tracking with one sequencer.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 40, physical address width, matching PHY_ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- req_val  in  NUM_REQ  one-cycle request pulse per requester.
- req_rqtype  in  5*NUM_REQ  L1.5 request type per requester. Slice i = [5i+4:5i].
- req_size  in  3*NUM_REQ  PCX size per requester.
- req_addr  in  ADDR_W*NUM_REQ  physical address per requester.
- req_data  in  64*NUM_REQ  store data per requester, already byte-ordered.
- req_busy  out  NUM_REQ  holding buffer i occupied.
- req_overflow  out  NUM_REQ  sticky: a request was dropped on requester i.
- l15_header_ack  in  1  L1.5 accepted header; requester must drop val.
- l15_ack  in  1  L1.5 accepted the full request.
- out_val  out  1  request valid to L1.5.
- out_rqtype  out  5  granted rqtype.
- out_size  out  3  granted size.
- out_addr  out  ADDR_W  granted address.
- out_data  out  64  granted data.
- out_nc  out  1  equals out_addr[ADDR_W-1].
- out_grant_id  out  3  index of the granted requester.

Behaviour:
- Reset: all buffers empty, req_busy = 0, req_overflow = 0, state = IDLE, all out_* = 0, round-robin pointer = NUM_REQ-1.
- Buffer capture: req_val[i] with buffer i empty captures the request. busy[i] = 1 the next cycle.
- Buffer full: req_val[i] with buffer i full and not released this cycle drops the request and sets overflow[i]. Overflow is cleared only by reset.
- Release plus arrival: if l15_ack releases buffer i in the same cycle req_val[i] arrives, the new request is captured and busy[i] stays 1.
- FSM IDLE: if any buffer is pending, select a winner and register its fields into out_* and out_grant_id. Go to ISSUE with out_val = 1 the next cycle. If nothing is pending, out_val = 0 and out_* hold their values.
- FSM ISSUE: out_val = 1 and out_* stable.
  - l15_ack: clear the winner's buffer, out_val = 0 next cycle, go to IDLE.
  - l15_header_ack without l15_ack: out_val = 0 next cycle, go to WAIT_ACK.
  - l15_ack and l15_header_ack together: treated as ack.
- FSM WAIT_ACK: out_val = 0 and out_* held. On l15_ack, clear the winner's buffer and go to IDLE. l15_header_ack in this state is ignored.
- Latency: req_val at cycle t into an idle arbiter gives out_val = 1 at t+2.
- Spacing: consecutive grants are separated by at least one cycle with out_val = 0, the IDLE cycle.
- Stability: a granted request is never pre-empted. out_* do not change from the selection cycle until ack.
- Arbitration (default build): fixed priority, lowest index wins.
- Reset mid-transaction: everything returns to reset values. Pending buffers are discarded and no ack is expected afterwards.
- l15_ack in IDLE: ignored, no state change.

Optional Feature:
- Macro: L15_REQ_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The winner is the first pending index after the pointer, wrapping modulo NUM_REQ. The pointer updates to the winner on each selection in IDLE.
- Undefined: fixed priority with index 0 highest. The pointer logic is absent.

Test Plan:
- Single request: req_val[1] = 1 at t, addr 0x00_8000_0040, rqtype 0x00, size 3'b111.
  - Expect out_val = 1 at t+2, out_grant_id = 1, out_addr = 0x0080000040, out_nc = 0.
  - l15_ack at t+4 gives out_val = 0 at t+5 and busy[1] = 0.
- Header-ack split: during ISSUE, assert l15_header_ack at cycle c.
  - Expect out_val = 0 from c+1 with out_* held.
  - l15_ack at c+3 frees the buffer and returns the FSM to IDLE.
- Fixed priority: req_val = 3'b111 in the same cycle, each acked 2 cycles after out_val.
  - Expect grants in order 0, 1, 2.
  - Expect out_val low for at least one cycle between grants.
- Round robin (macro defined): keep all three requesters continuously re-requesting.
  - Expect grant sequence 0, 1, 2, 0, 1, 2.
- Overflow: req_val[2] twice with no ack between.
  - Expect req_overflow[2] = 1, the first request's data 0xDEADBEEF_00000001 issued, and the second dropped.
- Release plus arrival: req_val[0] in the same cycle as l15_ack for grant 0.
  - Expect busy[0] to stay 1 and the new address issued next.
